// File: rtl/xor_ann.sv
// xor_ann: fixed-weight 2-2-1 perceptron with step activation.
// With the default weights the hidden layer forms OR (H1) and NAND (H2),
// and the output neuron ANDs them, so Y = A ^ B. The hidden activations are
// registered alongside Y so all three outputs always come from one sample.
module xor_ann #(
    parameter int W_WIDTH = 8,
    parameter int W_H1_A  = 2,
    parameter int W_H1_B  = 2,
    parameter int B_H1    = -1,
    parameter int W_H2_A  = -2,
    parameter int W_H2_B  = -2,
    parameter int B_H2    = 3,
    parameter int W_Y_H1  = 2,
    parameter int W_Y_H2  = 2,
    parameter int B_Y     = -3
) (
    input  logic clk,
    input  logic rst,
    input  logic A,
    input  logic B,
    output logic H1,
    output logic H2,
    output logic Y
);

    // Weights are held as W_WIDTH-bit two's complement values.
    localparam logic [W_WIDTH-1:0] WH1A = W_H1_A[W_WIDTH-1:0];
    localparam logic [W_WIDTH-1:0] WH1B = W_H1_B[W_WIDTH-1:0];
    localparam logic [W_WIDTH-1:0] BH1  = B_H1[W_WIDTH-1:0];
    localparam logic [W_WIDTH-1:0] WH2A = W_H2_A[W_WIDTH-1:0];
    localparam logic [W_WIDTH-1:0] WH2B = W_H2_B[W_WIDTH-1:0];
    localparam logic [W_WIDTH-1:0] BH2  = B_H2[W_WIDTH-1:0];
    localparam logic [W_WIDTH-1:0] WYH1 = W_Y_H1[W_WIDTH-1:0];
    localparam logic [W_WIDTH-1:0] WYH2 = W_Y_H2[W_WIDTH-1:0];
    localparam logic [W_WIDTH-1:0] BY   = B_Y[W_WIDTH-1:0];

    // Two extra bits cover the sum of three W_WIDTH-bit signed terms.
    localparam int S_WIDTH = W_WIDTH + 2;

    // Sign-extend a W_WIDTH-bit weight to the accumulator width.
    function automatic logic [S_WIDTH-1:0] sext(input logic [W_WIDTH-1:0] w);
        return {{2{w[W_WIDTH-1]}}, w};
    endfunction

    // One neuron: 0/1 inputs gate their weights; fires only on a strictly
    // positive sum (zero or negative gives 0).
    function automatic logic neuron(
        input logic               x0,
        input logic               x1,
        input logic [W_WIDTH-1:0] w0,
        input logic [W_WIDTH-1:0] w1,
        input logic [W_WIDTH-1:0] b
    );
        logic [S_WIDTH-1:0] sum;
        sum = (x0 ? sext(w0) : '0) + (x1 ? sext(w1) : '0) + sext(b);
        return !sum[S_WIDTH-1] && (sum != '0);
    endfunction

    logic h1_c;
    logic h2_c;
    logic y_c;

    // Combinational network: output layer uses the unregistered hidden values.
    always_comb begin
        h1_c = neuron(A, B, WH1A, WH1B, BH1);
        h2_c = neuron(A, B, WH2A, WH2B, BH2);
        y_c  = neuron(h1_c, h2_c, WYH1, WYH2, BY);
    end

    // Register all activations together; reset clears them synchronously.
    always_ff @(posedge clk) begin
        if (rst) begin
            H1 <= 1'b0;
            H2 <= 1'b0;
            Y  <= 1'b0;
        end else begin
            H1 <= h1_c;
            H2 <= h2_c;
            Y  <= y_c;
        end
    end

endmodule

// File: tb/tb_xor_ann.sv
// tb_xor_ann: directed checks of the XOR perceptron and parameter variants.
module tb_xor_ann;

  logic clk;
  logic rst;
  logic A;
  logic B;
  logic h1, h2, y;
  logic z_h1, z_h2, z_y;
  logic o_h1, o_h2, o_y;
  logic r_h1, r_h2, r_y;

  int checks = 0;
  int failures = 0;
  logic [0:0] exp_q[$];
  logic       y_prev;

  // default weights: XOR
  xor_ann dut (
    .clk(clk), .rst(rst), .A(A), .B(B), .H1(h1), .H2(h2), .Y(y)
  );

  // H1 sum is always exactly zero -> never fires
  xor_ann #(.W_H1_A(0), .W_H1_B(0), .B_H1(0)) dut_zero (
    .clk(clk), .rst(rst), .A(A), .B(B), .H1(z_h1), .H2(z_h2), .Y(z_y)
  );

  // H1 sum is always exactly one -> always fires
  xor_ann #(.W_H1_A(0), .W_H1_B(0), .B_H1(1)) dut_one (
    .clk(clk), .rst(rst), .A(A), .B(B), .H1(o_h1), .H2(o_h2), .Y(o_y)
  );

  // output neuron re-biased to OR of the hidden layer
  xor_ann #(.W_Y_H1(2), .W_Y_H2(2), .B_Y(-1)) dut_or (
    .clk(clk), .rst(rst), .A(A), .B(B), .H1(r_h1), .H2(r_h2), .Y(r_y)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // driver: change inputs on the falling edge, away from the sampling edge
  task automatic drive(input logic a, input logic b, input logic r);
    @(negedge clk);
    A = a;
    B = b;
    rst = r;
  endtask

  // wait for the sampling edge and settle
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [1:0] tv_in  [4];
  logic [2:0] tv_exp [4];
  logic [1:0] seq_in [4];
  logic       seq_y  [4];

  initial begin
    tv_in[0] = 2'b00; tv_exp[0] = 3'b010;
    tv_in[1] = 2'b01; tv_exp[1] = 3'b111;
    tv_in[2] = 2'b10; tv_exp[2] = 3'b111;
    tv_in[3] = 2'b11; tv_exp[3] = 3'b100;
    seq_in[0] = 2'b00; seq_y[0] = 1'b0;
    seq_in[1] = 2'b11; seq_y[1] = 1'b0;
    seq_in[2] = 2'b01; seq_y[2] = 1'b1;
    seq_in[3] = 2'b10; seq_y[3] = 1'b1;

    // reset held two cycles with A=1, B=0
    rst = 1'b1;
    A = 1'b1;
    B = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("reset_h1", h1, 1'b0);
      check("reset_h2", h2, 1'b0);
      check("reset_y", y, 1'b0);
      check("reset_or_y", r_y, 1'b0);
    end

    // truth table, one pair per cycle
    for (int i = 0; i < 4; i++) begin
      drive(tv_in[i][1], tv_in[i][0], 1'b0);
      tick();
      check($sformatf("tt%0d_h1", i), h1, tv_exp[i][2]);
      check($sformatf("tt%0d_h2", i), h2, tv_exp[i][1]);
      check($sformatf("tt%0d_y", i), y, tv_exp[i][0]);
    end

    // back-to-back sequence; Y must hold until the edge after each input
    y_prev = 1'b0;  // last truth-table pair was 11
    for (int i = 0; i < 4; i++) begin
      drive(seq_in[i][1], seq_in[i][0], 1'b0);
      exp_q.push_back(seq_y[i]);
      #1;
      check($sformatf("seq%0d_hold", i), y, y_prev);
      tick();
      y_prev = exp_q.pop_front();
      check($sformatf("seq%0d_y", i), y, y_prev);
    end

    // mid-stream reset pulse with A=0, B=1
    drive(1'b0, 1'b1, 1'b1);
    tick();
    check("mid_rst_h1", h1, 1'b0);
    check("mid_rst_h2", h2, 1'b0);
    check("mid_rst_y", y, 1'b0);
    drive(1'b0, 1'b1, 1'b0);
    tick();
    check("post_rst_h1", h1, 1'b1);
    check("post_rst_h2", h2, 1'b1);
    check("post_rst_y", y, 1'b1);

    // sum == 0 boundary, sum == 1, and OR-output variant over all inputs
    for (int i = 0; i < 4; i++) begin
      drive(tv_in[i][1], tv_in[i][0], 1'b0);
      tick();
      check($sformatf("zero_h1_%0d", i), z_h1, 1'b0);
      check($sformatf("one_h1_%0d", i), o_h1, 1'b1);
      check($sformatf("or_y_%0d", i), r_y, 1'b1);
      check($sformatf("zero_h2_%0d", i), z_h2, tv_exp[i][1]);
    end

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
